// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns and
// the active-low polarity of the segment and anode lines.
package seg7_pkg;

  // Logic levels on the active-low display lines.
  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_DARK = 1'b1;
  localparam logic AN_ON   = 1'b0;
  localparam logic AN_OFF  = 1'b1;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Full seg_n byte {p,g,f,e,d,c,b,a} per hex code with the point off;
  // element 0 is the rightmost entry of the concatenation.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-seven-segment decoder with decimal point, active-low
// output byte {p,g,f,e,d,c,b,a}.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_dp,
  output logic [7:0] o_seg_n
);

  logic [7:0] w_pattern;

  assign w_pattern = SEG_TABLE[i_code];
  assign o_seg_n   = {(i_dp ? SEG_ON : SEG_DARK), w_pattern[6:0]};

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: latches digit data, scans one digit
// per SCAN_DIV cycles with a dark guard cycle, and registers all outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS = 8,
  parameter  int SCAN_DIV   = 100000,
  localparam int IDX_W      = $clog2(NUM_DIGITS),
  localparam int PW         = $clog2(SCAN_DIV)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    le,
  input  logic                    blank,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [IDX_W-1:0]        scan_idx,
  output logic                    frame_tick
);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be in 2..16");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seg7_scan_driver: SCAN_DIV must be >= 2");
  end

  logic [PW-1:0]             r_presc;
  logic [IDX_W-1:0]          r_idx;
  logic [4*NUM_DIGITS-1:0]   r_hex;
  logic [NUM_DIGITS-1:0]     r_dp;
  logic                      r_wrap_evt;

  logic                      w_presc_wrap;
  logic                      w_idx_last;
  logic                      w_guard;
  logic [3:0]                w_code;
  logic                      w_dp;
  logic [NUM_DIGITS-1:0]     w_zero_from;
  logic                      w_lz_dark;
  logic                      w_dark;
  logic [7:0]                w_dec_seg_n;
  logic [7:0]                w_seg_n_next;
  logic [NUM_DIGITS-1:0]     w_an_n_next;

  assign w_presc_wrap = (r_presc == PW'(SCAN_DIV - 1));
  assign w_idx_last   = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_guard      = (r_presc == '0);

  assign w_code = r_hex[{r_idx, 2'b00} +: 4];
  assign w_dp   = r_dp[r_idx];

  // w_zero_from[i] is set when digits i..NUM_DIGITS-1 all hold code 0.
  always_comb begin
    w_zero_from = '0;
    w_zero_from[NUM_DIGITS-1] = (r_hex[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_zero_from[i] = w_zero_from[i+1] && (r_hex[4*i +: 4] == 4'h0);
    end
  end

  assign w_lz_dark = lz_en && (r_idx != '0) && w_zero_from[r_idx] && !w_dp;
  assign w_dark    = blank || !digit_en[r_idx] || w_lz_dark;

  seg7_hex_decode u_decode (
    .i_code  (w_code),
    .i_dp    (w_dp),
    .o_seg_n (w_dec_seg_n)
  );

  // The guard cycle only drops the anodes; segments may settle meanwhile.
  always_comb begin
    w_seg_n_next = w_dec_seg_n;
    w_an_n_next  = {NUM_DIGITS{AN_OFF}};
    if (w_dark) begin
      w_seg_n_next = SEG_OFF;
    end else if (!w_guard) begin
      w_an_n_next = ~(NUM_DIGITS'(1) << r_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_hex      <= '0;
      r_dp       <= '0;
      r_wrap_evt <= 1'b0;
      seg_n      <= SEG_OFF;
      an_n       <= {NUM_DIGITS{AN_OFF}};
      scan_idx   <= '0;
      frame_tick <= 1'b0;
    end else begin
      r_presc <= w_presc_wrap ? '0 : r_presc + PW'(1);
      if (w_presc_wrap) begin
        r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
      end
      if (!le) begin
        r_hex <= hex_in;
        r_dp  <= dp_in;
      end
      // Delayed one stage so the pulse lines up with the registered scan_idx.
      r_wrap_evt <= w_presc_wrap && w_idx_last;
      seg_n      <= w_seg_n_next;
      an_n       <= w_an_n_next;
      scan_idx   <= r_idx;
      frame_tick <= r_wrap_evt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, 4-cycle slots): directed scenarios and
// randomized control/data compared each cycle against a cycle-count model.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;

  logic          clk;
  logic          rst_n;
  logic [15:0]   hex_in;
  logic [3:0]    dp_in;
  logic          le;
  logic          blank;
  logic          lz_en;
  logic [3:0]    digit_en;
  logic [7:0]    seg_n;
  logic [3:0]    an_n;
  logic [1:0]    scan_idx;
  logic          frame_tick;

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .le         (le),
    .blank      (blank),
    .lz_en      (lz_en),
    .digit_en   (digit_en),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .scan_idx   (scan_idx),
    .frame_tick (frame_tick)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model & scoreboard ----------------
  logic [7:0] seg_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int unsigned n_total;
  int unsigned n_pass;
  int unsigned t_edges;
  logic [15:0] m_hex;
  logic [3:0]  m_dp;
  logic [14:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t_edges);
  endtask

  // Output after edge s+1 reflects the state reached after s edges since reset.
  function automatic logic [14:0] model_out(input int unsigned s);
    int unsigned presc = s % SD;
    int unsigned idx   = (s / SD) % ND;
    logic [3:0]  code  = m_hex[4*idx +: 4];
    logic        dpb   = m_dp[idx];
    logic        upper_zero = 1'b1;
    logic        dark;
    logic [3:0]  one = 4'b0001;
    logic [7:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_ft;
    for (int j = 0; j < ND; j++) begin
      if (j >= idx && m_hex[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    end
    dark  = blank || !digit_en[idx] || (lz_en && idx > 0 && upper_zero && !dpb);
    e_seg = dark ? 8'hFF : {~dpb, seg_ref[code][6:0]};
    e_an  = (dark || presc == 0) ? 4'hF : ~(one << idx);
    e_ft  = (s > 0) && (s % (SD * ND) == 0);
    return {e_seg, e_an, 2'(idx), e_ft};
  endfunction

  task automatic tick();
    logic [14:0] e;
    @(posedge clk);
    exp_q.push_back(model_out(t_edges));
    t_edges++;
    if (!le) begin
      m_hex = hex_in;
      m_dp  = dp_in;
    end
    #1;
    e = exp_q.pop_front();
    chk("seg_n",      {8'h0, seg_n},        {8'h0, e[14:7]});
    chk("an_n",       {12'h0, an_n},        {12'h0, e[6:3]});
    chk("scan_idx",   {14'h0, scan_idx},    {14'h0, e[2:1]});
    chk("frame_tick", {15'h0, frame_tick},  {15'h0, e[0]});
    chk("an_onehot",  {15'h0, ($countones(~an_n) <= 1)}, 16'h1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_dark_reset(input string tag);
    chk({tag, "_seg"},  {8'h0, seg_n},       16'h00FF);
    chk({tag, "_an"},   {12'h0, an_n},       16'h000F);
    chk({tag, "_idx"},  {14'h0, scan_idx},   16'h0000);
    chk({tag, "_ft"},   {15'h0, frame_tick}, 16'h0000);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    t_edges = 0;
    m_hex   = '0;
    m_dp    = '0;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int found;
    n_total = 0;
    n_pass  = 0;
    t_edges = 0;
    m_hex = '0;
    m_dp  = '0;
    rst_n = 1'b0;
    hex_in = 16'h1234; dp_in = 4'h0; le = 1'b0;
    blank = 1'b0; lz_en = 1'b0; digit_en = 4'hF;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 chk_dark_reset("reset");
    release_reset();

    // Basic scan of 1234.
    ticks(2);
    chk("lit_d0_seg", {8'h0, seg_n}, 16'h0099);
    chk("lit_d0_an",  {12'h0, an_n}, 16'h000E);
    ticks(12);
    chk("lit_d3_seg", {8'h0, seg_n}, 16'h00F9);
    chk("lit_d3_an",  {12'h0, an_n}, 16'h0007);
    ticks(3);
    chk("lit_frame_tick", {15'h0, frame_tick}, 16'h0001);
    ticks(20);

    // Leading-zero suppression, then point on a suppressible digit.
    hex_in = 16'h00A5; lz_en = 1'b1;
    ticks(34);
    dp_in = 4'b0100;
    ticks(34);
    dp_in = 4'b0000; lz_en = 1'b0;

    // Latch hold then release.
    hex_in = 16'h1234;
    ticks(3);
    le = 1'b1; hex_in = 16'hFFFF;
    ticks(20);
    le = 1'b0;
    ticks(2);
    chk("lit_release_8e", {8'h0, seg_n}, 16'h008E);
    ticks(16);

    // Blank mid-slot, digit enable mask.
    ticks(2);
    blank = 1'b1;
    ticks(1);
    chk("lit_blank_an",  {12'h0, an_n},  16'h000F);
    chk("lit_blank_seg", {8'h0, seg_n},  16'h00FF);
    ticks(18);
    blank = 1'b0; digit_en = 4'b1101;
    ticks(32);
    digit_en = 4'hF;

    // Randomized data and controls.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int d = 0; d < ND; d++)
          hex_in[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        dp_in    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        le       = ($urandom_range(0, 3) == 0);
        blank    = ($urandom_range(0, 7) == 0);
        lz_en    = $urandom_range(0, 1) != 0;
        digit_en = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      end
      tick();
    end

    // Asynchronous reset mid-slot of digit 2.
    le = 1'b1; blank = 1'b0; lz_en = 1'b0; digit_en = 4'hF; hex_in = 16'h1234;
    found = 0;
    for (int c = 0; c < 64 && found == 0; c++) begin
      tick();
      if (((t_edges - 1) / SD) % ND == 2 && (t_edges - 1) % SD == 2) found = 1;
    end
    chk("reach_idx2", 16'(found), 16'h1);
    #3 rst_n = 1'b0;
    #1 chk_dark_reset("async_rst");
    @(posedge clk);
    #1 chk_dark_reset("rst_hold");
    release_reset();
    ticks(2);
    chk("lit_after_rst_seg", {8'h0, seg_n}, 16'h00C0);
    chk("lit_after_rst_an",  {12'h0, an_n}, 16'h000E);
    ticks(14);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
